// File: rtl/mips_lite_pkg.sv
// rtl/mips_lite_pkg.sv - shared encodings for the MIPS-lite multi-cycle controller
// Contents: opcode/funct constants, FSM state codes, datapath select codes,
// ALU op helper for R/I-type execution.
package mips_lite_pkg;

  localparam int TIMER_W = 8;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FN_JR     = 6'b001000;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd15;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] WREG_RT = 2'b00;
  localparam logic [1:0] WREG_RD = 2'b01;
  localparam logic [1:0] WREG_RA = 2'b10;

  localparam logic [1:0] WDATA_ALU = 2'b00;
  localparam logic [1:0] WDATA_MDR = 2'b01;
  localparam logic [1:0] WDATA_PC4 = 2'b10;

  // ALU op for the execute/writeback pair; R-type defers to the funct field.
  function automatic logic [2:0] exec_alu_op(input logic [5:0] op);
    case (op)
      OP_RTYPE: exec_alu_op = ALU_FUNCT;
      OP_ANDI:  exec_alu_op = ALU_AND;
      OP_ORI:   exec_alu_op = ALU_OR;
      default:  exec_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ack_timer.sv
// rtl/ack_timer.sv - memory ack watchdog with sticky error flag
// Ports: clk, rst_n (async active-low); req/ack of the shared memory port;
// expire: the current unacked cycle is the last one allowed; mem_err: sticky.
module ack_timer
  import mips_lite_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic expire,
  output logic mem_err
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(ACK_TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt;

  // The counter is non-zero only while a request is outstanding, so expire
  // needs no req term; the FSM only looks at it in memory states.
  assign expire = !ack && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else if (req && !ack) begin
      if (expire) begin
        cnt     <= '0;
        mem_err <= 1'b1;
      end else begin
        cnt <= cnt + TIMER_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle sequencer for the MIPS-lite datapath
// Inputs: clk, rst_n, opcode/funct/rt from IR, flagz, a_msb, a_zero, mem_ack.
// Outputs: memory port (mem_req/mem_we/mem_isel), IR/MDR/PC strobes, pc_sel,
// ALU selects, register writeback selects, instr_done, illegal, mem_err.
module multicycle_control
  import mips_lite_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int ADDR_W      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       flagz,
  input  logic       a_msb,
  input  logic       a_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_isel,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       alu_srcb,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wreg_sel,
  output logic [1:0] wdata_sel,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err
);

  if (ADDR_W < 1 || ACK_TIMEOUT < 2 || ACK_TIMEOUT > 255) begin : g_param_check
    $error("multicycle_control: parameter out of range");
  end

  logic [3:0] state;
  logic [3:0] next_state;
  logic       expire;

  ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (mem_req),
    .ack     (mem_ack),
    .expire  (expire),
    .mem_err (mem_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_isel   = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = PC_INC;
    alu_srcb   = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    wreg_sel   = WREG_RT;
    wdata_sel  = WDATA_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_isel = 1'b1;
        if (mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (expire) begin
          next_state = S_HALT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                            next_state = (funct == FN_JR) ? S_JUMP : S_EXEC_R;
          OP_LW, OP_SW:                        next_state = S_ADDR;
          OP_BEQ, OP_BNE, OP_BGTZ, OP_REGIMM:  next_state = S_BRANCH;
          OP_J, OP_JAL:                        next_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:            next_state = S_EXEC_I;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_op     = exec_alu_op(opcode);
        wreg_sel   = WREG_RD;
        next_state = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_srcb   = 1'b1;
        alu_op     = exec_alu_op(opcode);
        next_state = S_WB_ALU;
      end
      S_WB_ALU: begin
        // Selects stay as in execute so the ALU result remains valid.
        alu_srcb   = (opcode != OP_RTYPE);
        alu_op     = exec_alu_op(opcode);
        wreg_sel   = (opcode == OP_RTYPE) ? WREG_RD : WREG_RT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_ADDR: begin
        alu_srcb   = 1'b1;
        next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        alu_srcb = 1'b1;
        if (mem_ack) begin
          mdr_write  = 1'b1;
          next_state = S_WB_MEM;
        end else if (expire) begin
          next_state = S_HALT;
        end
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        alu_srcb = 1'b1;
        if (mem_ack) begin
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else if (expire) begin
          next_state = S_HALT;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        wdata_sel  = WDATA_MDR;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_op     = ALU_SUB;
        pc_sel     = PC_BRANCH;
        instr_done = 1'b1;
        next_state = S_FETCH;
        case (opcode)
          OP_BEQ:    pc_write = flagz;
          OP_BNE:    pc_write = ~flagz;
          OP_BGTZ:   pc_write = ~a_msb & ~a_zero;
          OP_REGIMM: pc_write = (rt == RT_BGEZ) ? ~a_msb : ((rt == RT_BLTZ) ? a_msb : 1'b0);
          default:   pc_write = 1'b0;
        endcase
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
        case (opcode)
          OP_RTYPE: pc_sel = PC_REG;
          OP_JAL: begin
            pc_sel    = PC_JUMP;
            reg_write = 1'b1;
            wreg_sel  = WREG_RA;
            wdata_sel = WDATA_PC4;
          end
          default:  pc_sel = PC_JUMP;
        endcase
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase

    // State already reads FETCH during reset; keep every strobe quiet too.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_isel   = 1'b0;
      ir_write   = 1'b0;
      mdr_write  = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = PC_INC;
      alu_srcb   = 1'b0;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      wreg_sel   = WREG_RT;
      wdata_sel  = WDATA_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       flagz, a_msb, a_zero, mem_ack;
  logic       mem_req, mem_we, mem_isel, ir_write, mdr_write, pc_write;
  logic [1:0] pc_sel;
  logic       alu_srcb;
  logic [2:0] alu_op;
  logic       reg_write;
  logic [1:0] wreg_sel, wdata_sel;
  logic       instr_done, illegal, mem_err;
  logic [19:0] all_outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ACK_TIMEOUT(4), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
    .flagz(flagz), .a_msb(a_msb), .a_zero(a_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_isel(mem_isel), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_sel(pc_sel), .alu_srcb(alu_srcb),
    .alu_op(alu_op), .reg_write(reg_write), .wreg_sel(wreg_sel), .wdata_sel(wdata_sel),
    .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err)
  );

  assign all_outs = {mem_req, mem_we, mem_isel, ir_write, mdr_write, pc_write, pc_sel,
                     alu_srcb, alu_op, reg_write, wreg_sel, wdata_sel, instr_done,
                     illegal, mem_err};

  // {opcode, rt, flagz, a_msb, a_zero, expected pc_write}
  localparam logic [14:0] BR_TAB [13] = '{
    {6'b000100, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1},
    {6'b000100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0},
    {6'b000101, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0},
    {6'b000001, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1},
    {6'b000001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0},
    {6'b000001, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0},
    {6'b000001, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0},
    {6'b000001, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1},
    {6'b000001, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1},
    {6'b000111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0},
    {6'b000111, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0},
    {6'b000111, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1},
    {6'b000001, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0}
  };

  // {opcode, funct, pc_sel, reg_write, wreg_sel, wdata_sel}
  localparam logic [18:0] JMP_TAB [3] = '{
    {6'b000010, 6'b000000, 2'b10, 1'b0, 2'b00, 2'b00},
    {6'b000011, 6'b000000, 2'b10, 1'b1, 2'b10, 2'b10},
    {6'b000000, 6'b001000, 2'b11, 1'b0, 2'b00, 2'b00}
  };

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    flagz   = 1'b0;
    a_msb   = 1'b0;
    a_zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b1; opcode = 6'b100011; funct = 6'd0; rt = 5'd0;
    flagz = 1'b1; a_msb = 1'b1; a_zero = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs !== 20'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", all_outs, 20'd0);
    end
    checks++;
    if (dut.state !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dut.state);
    end
    @(posedge clk); #1 rst_n = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_isel, mem_we, mem_err} !== 4'b1100) begin
      errors++; $display("FAIL reset_release_fetch: got %b expected 1100", {mem_req, mem_isel, mem_we, mem_err});
    end
  endtask

  task automatic test_addi();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd0};
    do_reset();
    opcode = 6'b001000; funct = 6'b000101; rt = 5'b00010;
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 0);
      @(negedge clk);
      checks++;
      if (dut.state !== es[c]) begin
        errors++; $display("FAIL addi_state c%0d: got %0d expected %0d", c, dut.state, es[c]);
      end
      checks++;
      if (pc_write !== (c == 0)) begin
        errors++; $display("FAIL addi_pc_write c%0d: got %b expected %b", c, pc_write, (c == 0));
      end
      checks++;
      if ({reg_write, instr_done} !== {2{c == 3}}) begin
        errors++; $display("FAIL addi_wb c%0d: got %b expected %b", c, {reg_write, instr_done}, {2{c == 3}});
      end
      if (c == 2) begin
        checks++;
        if ({alu_srcb, alu_op} !== 4'b1000) begin
          errors++; $display("FAIL addi_exec: got %b expected 1000", {alu_srcb, alu_op});
        end
      end
      if (c == 3) begin
        checks++;
        if ({wreg_sel, wdata_sel} !== 4'b0000) begin
          errors++; $display("FAIL addi_wsel: got %b expected 0000", {wreg_sel, wdata_sel});
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_rtype();
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd7};
    do_reset();
    opcode = 6'b000000; funct = 6'b100000; rt = 5'd3;
    for (int c = 0; c < 4; c++) begin
      mem_ack = (c == 0);
      @(negedge clk);
      checks++;
      if (dut.state !== es[c]) begin
        errors++; $display("FAIL rtype_state c%0d: got %0d expected %0d", c, dut.state, es[c]);
      end
      if (c >= 2) begin
        checks++;
        if ({alu_srcb, alu_op, wreg_sel} !== 6'b011101) begin
          errors++; $display("FAIL rtype_sel c%0d: got %b expected 011101", c, {alu_srcb, alu_op, wreg_sel});
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] es [11] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd8, 4'd0};
    logic       er [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int mdr_pulses = 0;
    do_reset();
    opcode = 6'b100011; funct = 6'd4; rt = 5'd5;
    for (int c = 0; c < 11; c++) begin
      mem_ack = (c == 3) || (c == 8);
      @(negedge clk);
      if (mdr_write === 1'b1) mdr_pulses++;
      checks++;
      if ({dut.state, mem_req} !== {es[c], er[c]}) begin
        errors++; $display("FAIL lw_state_req c%0d: got %0d/%b expected %0d/%b", c, dut.state, mem_req, es[c], er[c]);
      end
      checks++;
      if ({mdr_write, instr_done} !== {c == 8, c == 9}) begin
        errors++; $display("FAIL lw_strobes c%0d: got %b expected %b", c, {mdr_write, instr_done}, {c == 8, c == 9});
      end
      if (c == 1 || c == 7) begin
        checks++;
        if (mem_isel !== (c == 1)) begin
          errors++; $display("FAIL lw_isel c%0d: got %b expected %b", c, mem_isel, (c == 1));
        end
      end
      if (c == 9) begin
        checks++;
        if ({reg_write, wdata_sel, wreg_sel} !== 5'b10100) begin
          errors++; $display("FAIL lw_wb: got %b expected 10100", {reg_write, wdata_sel, wreg_sel});
        end
      end
      next_cycle();
    end
    checks++;
    if (mdr_pulses != 1) begin
      errors++; $display("FAIL lw_mdr_pulses: got %0d expected 1", mdr_pulses);
    end
  endtask

  task automatic test_sw();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd0};
    do_reset();
    opcode = 6'b101011; funct = 6'd0; rt = 5'd1;
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 0) || (c == 3);
      @(negedge clk);
      checks++;
      if (dut.state !== es[c]) begin
        errors++; $display("FAIL sw_state c%0d: got %0d expected %0d", c, dut.state, es[c]);
      end
      checks++;
      if ({mem_we, instr_done, reg_write} !== {c == 3, c == 3, 1'b0}) begin
        errors++; $display("FAIL sw_strobes c%0d: got %b expected %b", c, {mem_we, instr_done, reg_write}, {c == 3, c == 3, 1'b0});
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    logic [14:0] v;
    for (int i = 0; i < 13; i++) begin
      v = BR_TAB[i];
      do_reset();
      opcode = v[14:9]; rt = v[8:4]; funct = 6'd0;
      flagz = v[3]; a_msb = v[2]; a_zero = v[1];
      mem_ack = 1'b1; next_cycle();
      mem_ack = 1'b0; next_cycle();
      @(negedge clk);
      checks++;
      if (dut.state !== 4'd9) begin
        errors++; $display("FAIL branch_state v%0d: got %0d expected 9", i, dut.state);
      end
      checks++;
      if ({pc_write, pc_sel, instr_done, alu_op, alu_srcb} !== {v[0], 2'b01, 1'b1, 3'b001, 1'b0}) begin
        errors++; $display("FAIL branch_out v%0d: got %b expected %b", i,
                           {pc_write, pc_sel, instr_done, alu_op, alu_srcb}, {v[0], 2'b01, 1'b1, 3'b001, 1'b0});
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (dut.state !== 4'd0) begin
        errors++; $display("FAIL branch_return v%0d: got %0d expected 0", i, dut.state);
      end
    end
  endtask

  task automatic test_jump();
    logic [18:0] v;
    for (int i = 0; i < 3; i++) begin
      v = JMP_TAB[i];
      do_reset();
      opcode = v[18:13]; funct = v[12:7]; rt = 5'd0;
      mem_ack = 1'b1; next_cycle();
      mem_ack = 1'b0; next_cycle();
      @(negedge clk);
      checks++;
      if ({dut.state, pc_write, instr_done} !== {4'd10, 2'b11}) begin
        errors++; $display("FAIL jump_state v%0d: got %0d/%b expected 10/11", i, dut.state, {pc_write, instr_done});
      end
      checks++;
      if ({pc_sel, reg_write, wreg_sel, wdata_sel} !== v[6:0]) begin
        errors++; $display("FAIL jump_out v%0d: got %b expected %b", i, {pc_sel, reg_write, wreg_sel, wdata_sel}, v[6:0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'b111111; funct = 6'd0; rt = 5'd0;
    mem_ack = 1'b1; next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({illegal, instr_done, reg_write, pc_write} !== 4'b1100) begin
      errors++; $display("FAIL illegal_pulse: got %b expected 1100", {illegal, instr_done, reg_write, pc_write});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({dut.state, illegal} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL illegal_return: got %0d/%b expected 0/0", dut.state, illegal);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 6'b100011; funct = 6'd0; rt = 5'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_err} !== 2'b10) begin
        errors++; $display("FAIL timeout_wait c%0d: got %b expected 10", c, {mem_req, mem_err});
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({dut.state, mem_req, mem_err} !== {4'd15, 2'b01}) begin
      errors++; $display("FAIL timeout_halt: got %0d/%b expected 15/01", dut.state, {mem_req, mem_err});
    end
    mem_ack = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({dut.state, all_outs} !== {4'd15, 20'd1}) begin
      errors++; $display("FAIL timeout_sticky: got %0d/%h expected 15/00001", dut.state, all_outs);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_lw();
    // Starts from HALT with mem_err set; reset must clear both.
    rst_n = 1'b1;
    opcode = 6'b100011; funct = 6'd0; rt = 5'd0;
    do_reset();
    mem_ack = 1'b1; next_cycle();
    mem_ack = 1'b0; next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({dut.state, mem_req} !== {4'd5, 1'b1}) begin
      errors++; $display("FAIL midlw_memrd: got %0d/%b expected 5/1", dut.state, mem_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dut.state, all_outs} !== {4'd0, 20'd0}) begin
      errors++; $display("FAIL midlw_reset: got %0d/%h expected 0/00000", dut.state, all_outs);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({dut.state, mem_req, mem_isel} !== {4'd0, 2'b11}) begin
      errors++; $display("FAIL midlw_release: got %0d/%b expected 0/11", dut.state, {mem_req, mem_isel});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_addi();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_lw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
